fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage. Owns the PC register and the IF/ID pipeline latch, and drives a req/ready handshake to instruction memory. Applies load-use stalls from ID and branch redirects from EX/MEM, with flush. Sits between EX/MEM branch resolution and the ID stage, replacing free-running PC update with a handshake-aware state machine.

---
 rtl/fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, IF/ID latch, imem req/ready handshake
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INCR  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mem_pc_src,
    input  logic [31:0] ex_mem_npc,
    input  logic        hazard_stall,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_npc,
    output logic        if_id_valid
);

    // FETCH: request outstanding (or start-up cycle); HOLD: response parked in skid
    // buffer while ID stalls; DRAIN: waiting out a response that a redirect killed.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_npc;
    logic        r_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_npc;
    logic [31:0] r_target;

    logic [31:0] w_pc_seq;
    logic [31:0] w_redir_tgt;

    assign w_pc_seq    = r_pc + PC_INCR;
    assign w_redir_tgt = {ex_mem_npc[31:2], 2'b00};

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_npc   = r_npc;
    assign if_id_valid = r_valid;

    // Fetch sequencer: state, PC, IF/ID latch and skid buffer with registered request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_req        <= 1'b0;
            r_pc         <= RESET_PC;
            r_instr      <= 32'd0;
            r_npc        <= 32'd0;
            r_valid      <= 1'b0;
            r_skid_instr <= 32'd0;
            r_skid_npc   <= 32'd0;
            r_target     <= 32'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_req) begin
                        // First cycle out of reset: nothing is outstanding, so a
                        // redirect can retarget the PC directly.
                        r_req <= 1'b1;
                        if (ex_mem_pc_src) begin
                            r_pc    <= w_redir_tgt;
                            r_valid <= 1'b0;
                        end
                    end else if (ex_mem_pc_src) begin
                        r_valid <= 1'b0;
                        if (imem_ready) begin
                            r_pc <= w_redir_tgt;
                        end else begin
                            // Address must not change mid-request; wait it out.
                            r_target <= w_redir_tgt;
                            r_state  <= S_DRAIN;
                        end
                    end else if (imem_ready) begin
                        r_pc <= w_pc_seq;
                        if (hazard_stall) begin
                            r_skid_instr <= imem_rdata;
                            r_skid_npc   <= w_pc_seq;
                            r_req        <= 1'b0;
                            r_state      <= S_HOLD;
                        end else begin
                            r_instr <= imem_rdata;
                            r_npc   <= w_pc_seq;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (ex_mem_pc_src) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_redir_tgt;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end else if (!hazard_stall) begin
                        r_instr <= r_skid_instr;
                        r_npc   <= r_skid_npc;
                        r_valid <= 1'b1;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // Latest redirect wins, including one arriving with the response.
                    if (imem_ready) begin
                        r_pc    <= ex_mem_pc_src ? w_redir_tgt : r_target;
                        r_state <= S_FETCH;
                    end else if (ex_mem_pc_src) begin
                        r_target <= w_redir_tgt;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a transaction-level model
module tb_fetch_ctrl;

    localparam logic [31:0] MEMX = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mem_pc_src;
    logic [31:0] ex_mem_npc;
    logic        hazard_stall;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: word content is a scrambled copy of its address.
    assign imem_rdata = imem_addr ^ MEMX;

    fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_mem_pc_src(ex_mem_pc_src),
        .ex_mem_npc   (ex_mem_npc),
        .hazard_stall (hazard_stall),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .if_id_instr  (if_id_instr),
        .if_id_npc    (if_id_npc),
        .if_id_valid  (if_id_valid)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
        logic [31:0] tgt;
        logic [31:0] sk_instr;
        logic [31:0] sk_npc;
        logic        valid;
        logic        started;
        logic        holding;
        logic        draining;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t r;
        r = '0;
        return r;
    endfunction

    // One clock of the fetch rules: redirect beats stall beats advance.
    function automatic mstate_t model_next(input mstate_t c, input logic rdy, input logic stl,
                                           input logic red, input logic [31:0] raw);
        mstate_t     n;
        logic [31:0] tgt;
        logic [31:0] word;
        n    = c;
        tgt  = raw & 32'hFFFF_FFFC;
        word = c.pc ^ MEMX;
        if (!c.started) begin
            n.started = 1'b1;
            if (red) begin
                n.pc    = tgt;
                n.valid = 1'b0;
            end
        end else if (c.holding) begin
            if (red) begin
                n.valid   = 1'b0;
                n.pc      = tgt;
                n.holding = 1'b0;
            end else if (!stl) begin
                n.instr   = c.sk_instr;
                n.npc     = c.sk_npc;
                n.valid   = 1'b1;
                n.holding = 1'b0;
            end
        end else if (c.draining) begin
            if (red) n.tgt = tgt;
            if (rdy) begin
                n.pc       = n.tgt;
                n.draining = 1'b0;
            end
        end else if (red) begin
            n.valid = 1'b0;
            if (rdy) n.pc = tgt;
            else begin
                n.tgt      = tgt;
                n.draining = 1'b1;
            end
        end else if (rdy) begin
            if (stl) begin
                n.sk_instr = word;
                n.sk_npc   = c.pc + 32'd4;
                n.holding  = 1'b1;
            end else begin
                n.instr = word;
                n.npc   = c.pc + 32'd4;
                n.valid = 1'b1;
            end
            n.pc = c.pc + 32'd4;
        end
        return n;
    endfunction

    // Model state tracks the DUT's clock and asynchronous reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, imem_ready, hazard_stall, ex_mem_pc_src, ex_mem_npc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model on each falling edge
    always @(negedge clk) begin
        chk("imem_req",    {31'd0, imem_req}, {31'd0, m.started & ~m.holding});
        chk("imem_addr",   imem_addr,   m.pc);
        chk("pc",          pc,          m.pc);
        chk("if_id_instr", if_id_instr, m.instr);
        chk("if_id_npc",   if_id_npc,   m.npc);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m.valid});
    end

    task automatic cyc(input logic r, input logic s, input logic p, input logic [31:0] n);
        imem_ready    = r;
        hazard_stall  = s;
        ex_mem_pc_src = p;
        ex_mem_npc    = n;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] vec [0:15];

    initial begin
        rst_n = 1'b0;
        ex_mem_pc_src = 1'b0;
        ex_mem_npc = 32'd0;
        hazard_stall = 1'b0;
        imem_ready = 1'b0;
        vec = '{3'b100, 3'b000, 3'b100, 3'b110, 3'b011, 3'b000, 3'b100, 3'b001,
                3'b000, 3'b101, 3'b110, 3'b111, 3'b100, 3'b010, 3'b100, 3'b100};

        @(posedge clk); #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // zero-wait memory
        cyc(1, 0, 0, 0);
        chk("start_req", {31'd0, imem_req}, 32'd1);
        chk("start_addr", imem_addr, 32'h0);
        chk("start_valid", {31'd0, if_id_valid}, 32'd0);
        cyc(1, 0, 0, 0);
        chk("zw0_instr", if_id_instr, 32'hC0DE_0000);
        chk("zw0_npc", if_id_npc, 32'h4);
        chk("zw0_valid", {31'd0, if_id_valid}, 32'd1);
        cyc(1, 0, 0, 0);
        chk("zw1_instr", if_id_instr, 32'hC0DE_0004);
        chk("zw1_npc", if_id_npc, 32'h8);

        // two wait states at pc=8
        cyc(0, 0, 0, 0);
        chk("wait1_addr", imem_addr, 32'h8);
        chk("wait1_npc", if_id_npc, 32'h8);
        cyc(0, 0, 0, 0);
        chk("wait2_addr", imem_addr, 32'h8);
        cyc(1, 0, 0, 0);
        chk("wait_instr", if_id_instr, 32'hC0DE_0008);
        chk("wait_npc", if_id_npc, 32'hC);
        chk("wait_pc", pc, 32'hC);

        // load-use stall for three cycles as pc=12 returns
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_npc", if_id_npc, 32'hC);
        chk("hold_pc", pc, 32'h10);
        cyc(1, 0, 0, 0);
        chk("unhold_instr", if_id_instr, 32'hC0DE_000C);
        chk("unhold_npc", if_id_npc, 32'h10);
        chk("unhold_addr", imem_addr, 32'h10);
        cyc(1, 0, 0, 0);

        // redirect while pc=20 is waiting
        cyc(0, 0, 1, 32'h40);
        chk("drain_valid", {31'd0, if_id_valid}, 32'd0);
        chk("drain_addr", imem_addr, 32'h14);
        cyc(0, 0, 0, 0);
        chk("drain_addr2", imem_addr, 32'h14);
        cyc(1, 0, 0, 0);
        chk("redir_pc", pc, 32'h40);
        chk("redir_valid", {31'd0, if_id_valid}, 32'd0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 32'h60);
        cyc(0, 1, 1, 32'h80);
        cyc(1, 0, 0, 0);
        chk("latest_pc", pc, 32'h80);

        // redirect + stall together while in HOLD
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("hold2_req", {31'd0, imem_req}, 32'd0);
        cyc(0, 1, 1, 32'h43);
        chk("hredir_pc", pc, 32'h40);
        chk("hredir_valid", {31'd0, if_id_valid}, 32'd0);
        chk("hredir_instr", if_id_instr, 32'hC0DE_0080);
        chk("hredir_req", {31'd0, imem_req}, 32'd1);

        // wrap at the top of the address space; redirect beats stall
        cyc(1, 1, 1, 32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);
        cyc(1, 0, 0, 0);
        chk("wrap_npc", if_id_npc, 32'h0);
        chk("wrap_instr", if_id_instr, 32'h3F21_FFFC);
        chk("wrap_next", pc, 32'h0);

        // asynchronous reset in the middle of a waiting request
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_instr", if_id_instr, 32'h0);
        chk("arst_npc", if_id_npc, 32'h0);
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // reset during DRAIN drops the pending target
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 32'h200);
        #2 rst_n = 1'b0;
        #1;
        chk("drst_pc", pc, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("drst_next_pc", pc, 32'h4);
        chk("drst_valid", {31'd0, if_id_valid}, 32'd1);

        // mixed directed vectors checked by the model
        for (int i = 0; i < 16; i++) begin
            cyc(vec[i][2], vec[i][1], vec[i][0], 32'h100 + 32'(i * 16) + 32'd3);
        end
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        @(negedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
